// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access stage.
// Holds the FSM encoding, load/store opcode matches and the timeout limit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef struct packed {
    logic load;
    logic store;
  } ls_t;

  localparam logic [2:0] LD_OP_HI  = 3'b110;
  localparam logic [3:0] LD_OP_ALT = 4'b1000;
  localparam logic [2:0] ST_OP_HI  = 3'b111;
  localparam logic [3:0] ST_OP_ALT = 4'b1001;

  localparam logic [3:0] TIMEOUT_MAX = 4'd15;

endpackage

// File: rtl/mem_access_unit_pipeline.sv
// Opcode field decode for the memory access stage.
// Classifies a 7-bit opcode as load, store or neither.
import mem_access_unit_pkg::*;

module pipeline_unit (
  input  logic [6:0] opcode,
  output ls_t        ls
);

  always_comb begin
    ls.load  = (opcode[6:4] == LD_OP_HI)
            || (opcode[6:3] == LD_OP_ALT);
    ls.store = (opcode[6:4] == ST_OP_HI)
            || (opcode[6:3] == ST_OP_ALT);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: captures an instruction, runs one data memory
// access per load/store with ack timeout, epoch squash and load capture.
import mem_access_unit_pkg::*;

module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        branch_ref,
  input  logic        branch_in,
  input  logic        sel_stall,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        branch_value,
  output logic        valid_out,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] ldr_data,
  output logic        stall_req,
  output logic        mem_err
);

  state_t     state;
  state_t     state_nxt;
  ls_t        dec;
  ls_t        cur;
  logic       busy;
  logic       hold;
  logic       cap_ok;
  logic       kill;
  logic       tmo;
  logic       abort;
  logic [3:0] cnt;

  pipeline_unit u_dec (
    .opcode (instr_in[6:0]),
    .ls     (dec)
  );

  // hold comes from state, not stall_req, to keep the loop out of comb
  assign busy   = (state == ACCESS);
  assign hold   = sel_stall | busy;
  assign cap_ok = !hold
               && (branch_in == branch_ref)
               && (dec.load || dec.store);

  assign valid_out = (branch_value == branch_ref) && !kill;

  assign tmo   = busy && !mem_ack
              && (cnt == TIMEOUT_MAX);
  assign abort = busy && !mem_ack && cur.load
              && (branch_value != branch_ref);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    stall_req = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_nxt = cap_ok ? ACCESS : IDLE;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_wr    = cur.store;
        stall_req = 1'b1;
        if (mem_ack)
          state_nxt = DONE;
        else if (tmo || abort)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      instr_out    <= '0;
      branch_value <= 1'b0;
      cur          <= '0;
      kill         <= 1'b0;
      cnt          <= '0;
      ldr_data     <= '0;
      mem_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= busy ? cnt + 4'd1 : 4'd0;
      if (!hold) begin
        instr_out    <= instr_in;
        branch_value <= branch_in;
        cur          <= dec;
        kill         <= 1'b0;
      end else if (tmo) begin
        kill <= 1'b1;
      end
      if (busy && mem_ack && cur.load)
        ldr_data <= mem_rdata;
      if (tmo)
        mem_err <= 1'b1;
    end
  end

endmodule
